alu_result_formatter: RTL and testbench
=======================================

// Module: alu_result_formatter
// PURPOSE
//  Consumer end of the calculator ALU interface: accepts an ALU result (s, signal, fct) over a
//  valid/ready handshake and converts it into sign + packed BCD digits for the display path.
//  Conversion is iterative: shift-add-3 (double dabble), one bit per clock.
//  Sits between the combinational ALU output and the display/digit driver.
// PARAMETERS
//  width   8   ALU operand width; the result bus is 2*width bits
//  DIGITS  ((2*width*1233)>>12)+1 (localparam, =5 for width=8)   BCD digits needed for 2^(2*width)-1
// PORTS
//  clk_i      in   1            clock; all logic on rising edge
//  rst_ni     in   1            reset, synchronous, active-low
//  s_i        in   2*width      ALU result
//  signal_i   in   1            ALU compare flag
//  fct_i      in   2            ALU function code that produced s_i/signal_i
//  valid_i    in   1            input handshake: result present
//  ready_o    out  1            input handshake: formatter can accept
//  bcd_o      out  4*DIGITS     packed BCD, digit 0 = bits [3:0] = least significant
//  neg_o      out  1            result is negative (subtraction only)
//  valid_o    out  1            output handshake: bcd_o/neg_o valid
//  ready_i    in   1            output handshake: consumer takes result
// BEHAVIOUR
//  - Reset (rst_ni=0 at a clock edge): state IDLE; ready_o=1; valid_o=0; bcd_o=0; neg_o=0; counter=0.
//    This is valid from any state, including mid-conversion; a partial result is discarded.
//  - FSM: IDLE -> CONV on valid_i&&ready_o; CONV -> DONE after 2*width iterations;
//    DONE -> IDLE on ready_i.
//  - ready_o=1 only in IDLE. valid_i is ignored in CONV and DONE; there is no queuing.
//  - Capture at the accept edge:
//      fct=00 add, fct=10 mul: magnitude=s_i, neg=0.
//      fct=01 sub: if s_i[2*width-1]=1 then magnitude=(~s_i)+1 (2*width bits), neg=1;
//        otherwise magnitude=s_i, neg=0.
//      fct=11 cmp: magnitude={0..,signal_i}, neg=0; s_i is ignored.
//  - CONV: on each edge, add 3 to every BCD nibble >=5, then shift {bcd,mag} left by 1.
//    This runs exactly 2*width edges; the counter runs 0..2*width-1.
//  - Latency: valid_o rises in the cycle after edge t+2*width, where t is the accept edge.
//  - DONE: valid_o=1. bcd_o and neg_o hold stable until an edge with ready_i=1; then valid_o=0
//    and ready_o=1 from the next cycle. There is no back-to-back accept in the same edge.
//  - bcd_o and neg_o update only on the CONV->DONE edge, and hold their values in IDLE.
//    ready_i is ignored outside DONE.
//  - Magnitude 0 yields all-zero BCD. The maximum 2^(2*width)-1 must fit DIGITS without overflow.
// CONFIGURATION
//  Macro ALU_FMT_ZERO_BLANK_EN:
//   defined: adds output blank_o [DIGITS-1:0], registered with bcd_o. Bit k=1 when digit k and
//     all higher digits are zero. blank_o[0] is always 0. Reset value is 0.
//   undefined: blank_o port and its logic are absent. All other behaviour is identical.
// STRUCTURE
//  Package alu_pkg:
//   - fct_e enum: FCT_ADD=2'b00, FCT_SUB=2'b01, FCT_MUL=2'b10, FCT_CMP=2'b11
//   - fmt_state_e enum: IDLE, CONV, DONE
//   - function bcd_digits(int w), returning ((2*w*1233)>>12)+1
//  Sub-module bcd_add3 (4-bit in/out, combinational, nibble>=5 ? nibble+3 : nibble).
//   Instantiated DIGITS times by generate.
// TESTING
//  1 add: fct=00, s=16'd255 -> bcd_o=20'h00255, neg_o=0; valid_o exactly 16 edges after accept.
//  2 sub: fct=01, s=16'hFFFB (5-10) -> bcd_o=20'h00005, neg_o=1; fct=01, s=16'd7 -> 20'h00007, neg_o=0.
//  3 mul: fct=10, s=16'd65025 (255*255) -> bcd_o=20'h65025; s=16'hFFFF -> 20'h65535.
//  4 cmp: fct=11, signal=1, s=16'h1234 -> bcd_o=20'h00001; signal=0 -> 20'h00000.
//  5 backpressure: ready_i=0 for 10 cycles in DONE -> bcd_o, valid_o stable; ready_o=0;
//    a valid_i pulse is not accepted. After ready_i=1: valid_o=0 and ready_o=1 next cycle.
//  6 reset: rst_ni=0 at edge 5 of CONV -> next cycle valid_o=0, ready_o=1, bcd_o=0. A following
//    s=16'd100 add converts to 20'h00100. With ALU_FMT_ZERO_BLANK_EN: 255 -> blank_o=5'b11000.

Source files
------------

// File: rtl/alu_result_formatter_pkg.sv
// Shared types and sizing helper for the ALU result formatter.
// Optional feature macro: ALU_FMT_ZERO_BLANK_EN (adds blank_o leading-zero mask).
package alu_pkg;

  typedef enum logic [1:0] {
    FCT_ADD = 2'b00,
    FCT_SUB = 2'b01,
    FCT_MUL = 2'b10,
    FCT_CMP = 2'b11
  } fct_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CONV = 2'b01,
    DONE = 2'b10
  } fmt_state_e;

  // Decimal digits needed for 2^(2*w)-1; 1233/4096 approximates log10(2).
  function automatic int bcd_digits(int w);
    return ((2 * w * 1233) >> 12) + 1;
  endfunction

endpackage

// File: rtl/alu_result_formatter_if.sv
// Handshake bundle between the ALU, the formatter and the display consumer.
// Optional feature macro: ALU_FMT_ZERO_BLANK_EN (adds blank_o).
interface alu_fmt_if #(parameter int width = 8);
  import alu_pkg::*;
  localparam int DIGITS = bcd_digits(width);

  logic [2*width-1:0]  s_i;
  logic                signal_i;
  logic [1:0]          fct_i;
  logic                valid_i;
  logic                ready_o;
  logic [4*DIGITS-1:0] bcd_o;
  logic                neg_o;
  logic                valid_o;
  logic                ready_i;
`ifdef ALU_FMT_ZERO_BLANK_EN
  logic [DIGITS-1:0]   blank_o;
`endif

  // Formatter side
  modport slave (
    input  s_i, signal_i, fct_i, valid_i, ready_i,
`ifdef ALU_FMT_ZERO_BLANK_EN
    output blank_o,
`endif
    output ready_o, bcd_o, neg_o, valid_o
  );

  // Producer/consumer side
  modport master (
    output s_i, signal_i, fct_i, valid_i, ready_i,
`ifdef ALU_FMT_ZERO_BLANK_EN
    input  blank_o,
`endif
    input  ready_o, bcd_o, neg_o, valid_o
  );

endinterface

// File: rtl/alu_result_formatter_bcd_add3.sv
// Double-dabble correction cell: add 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  // Pre-shift correction so the nibble carries into the next digit correctly
  always_comb begin
    d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
  end
endmodule

// File: rtl/alu_result_formatter.sv
// ALU result formatter: sign + packed BCD via iterative double dabble,
// one result bit per clock.
// Optional feature macro: ALU_FMT_ZERO_BLANK_EN (adds blank_o leading-zero mask).
module alu_result_formatter
  import alu_pkg::*;
#(
  parameter int width = 8
) (
  input logic      clk_i,
  input logic      rst_ni,
  alu_fmt_if.slave bus
);
  localparam int DIGITS = bcd_digits(width);
  localparam int MW     = 2 * width;
  localparam int BW     = 4 * DIGITS;
  localparam int CNT_W  = (MW > 1) ? $clog2(MW) : 1;

  fmt_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MW-1:0]     mag_q, mag_d;
  logic [BW-1:0]     work_q, work_d;
  logic              neg_work_q, neg_work_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              neg_q, neg_d;
  logic [DIGITS-1:0] blank_q, blank_d, blank_nxt;

  logic [BW-1:0]     work_adj;
  logic [BW+MW-1:0]  cat_shift;

  // One correction cell per digit of the working register
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (.d_i(work_q[4*g +: 4]), .d_o(work_adj[4*g +: 4]));
  end

  // One double-dabble step: corrected digits and magnitude shift left together
  always_comb begin
    cat_shift = {work_adj, mag_q} << 1;
  end

  // Leading-zero mask of the finished value; digit 0 is always shown
  always_comb begin
    blank_nxt = '0;
    for (int k = 1; k < DIGITS; k++) begin
      blank_nxt[k] = 1'b1;
      for (int j = k; j < DIGITS; j++) begin
        if (cat_shift[MW + 4*j +: 4] != 4'd0) blank_nxt[k] = 1'b0;
      end
    end
  end

  // Next-state, capture and conversion step
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    work_d     = work_q;
    neg_work_d = neg_work_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    blank_d    = blank_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          state_d    = CONV;
          cnt_d      = '0;
          work_d     = '0;
          mag_d      = bus.s_i;
          neg_work_d = 1'b0;
          case (fct_e'(bus.fct_i))
            FCT_SUB: begin
              if (bus.s_i[MW-1]) begin
                mag_d      = (~bus.s_i) + MW'(1);
                neg_work_d = 1'b1;
              end
            end
            FCT_CMP: mag_d = {{(MW-1){1'b0}}, bus.signal_i};
            default: mag_d = bus.s_i;
          endcase
        end
      end
      CONV: begin
        mag_d  = cat_shift[MW-1:0];
        work_d = cat_shift[BW+MW-1 -: BW];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MW - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          bcd_d   = cat_shift[BW+MW-1 -: BW];
          neg_d   = neg_work_q;
          blank_d = blank_nxt;
        end
      end
      DONE: begin
        if (bus.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial conversion
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      work_q     <= '0;
      neg_work_q <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      blank_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      work_q     <= work_d;
      neg_work_q <= neg_work_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      blank_q    <= blank_d;
    end
  end

  // Handshake outputs follow the state directly
  always_comb begin
    bus.ready_o = (state_q == IDLE);
    bus.valid_o = (state_q == DONE);
    bus.bcd_o   = bcd_q;
    bus.neg_o   = neg_q;
  end

`ifdef ALU_FMT_ZERO_BLANK_EN
  // Blank mask registered alongside bcd_o
  always_comb begin
    bus.blank_o = blank_q;
  end
`else
  logic unused_blank;
  always_comb begin
    unused_blank = ^blank_q;
  end
`endif

endmodule

// File: tb/tb_alu_result_formatter.sv
// Directed bench for alu_result_formatter with an expected-result scoreboard.
module tb_alu_result_formatter;
  import alu_pkg::*;

  typedef struct {
    logic [19:0] bcd;
    logic        neg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  alu_fmt_if #(.width(8)) bus();

  alu_result_formatter #(.width(8)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one result, measure latency, score it, optionally hold off the consumer
  task automatic run(input string tag, input logic [1:0] f, input logic [15:0] s,
                     input logic sig, input logic [19:0] eb, input logic en,
                     input int hold);
    int   n;
    exp_t e;
    @(negedge clk);
    chk({tag, "_ready_idle"}, 32'(bus.ready_o), 32'd1);
    bus.fct_i    = f;
    bus.s_i      = s;
    bus.signal_i = sig;
    bus.valid_i  = 1'b1;
    sb.push_back('{eb, en});
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    n = 0;
    while (!bus.valid_o && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(n), 32'd16);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_bcd"}, 32'(bus.bcd_o), 32'(e.bcd));
      chk({tag, "_neg"}, 32'(bus.neg_o), 32'(e.neg));
    end else begin
      e = '{20'h0, 1'b0};
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin
        bus.s_i     = 16'd999;
        bus.fct_i   = 2'b00;
        bus.valid_i = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      bus.valid_i = 1'b0;
      chk({tag, "_bp_valid"}, 32'(bus.valid_o), 32'd1);
      chk({tag, "_bp_ready"}, 32'(bus.ready_o), 32'd0);
      chk({tag, "_bp_bcd"},   32'(bus.bcd_o),   32'(e.bcd));
    end
    bus.ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ready_i = 1'b0;
    chk({tag, "_rel_valid"}, 32'(bus.valid_o), 32'd0);
    chk({tag, "_rel_ready"}, 32'(bus.ready_o), 32'd1);
    chk({tag, "_hold_bcd"},  32'(bus.bcd_o),   32'(e.bcd));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.s_i = '0; bus.signal_i = 1'b0; bus.fct_i = 2'b00;
    bus.valid_i = 1'b0; bus.ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_bcd",   32'(bus.bcd_o),   32'd0);
    chk("rst_neg",   32'(bus.neg_o),   32'd0);

    run("add255", 2'b00, 16'd255, 1'b0, 20'h00255, 1'b0, 0);
`ifdef ALU_FMT_ZERO_BLANK_EN
    chk("blank255", 32'(bus.blank_o), 32'b11000);
`endif
    run("sub_neg", 2'b01, 16'hFFFB, 1'b0, 20'h00005, 1'b1, 0);
    run("sub_pos", 2'b01, 16'd7,    1'b0, 20'h00007, 1'b0, 0);
    run("mul255",  2'b10, 16'd65025, 1'b0, 20'h65025, 1'b0, 0);
    run("cmp1",    2'b11, 16'h1234, 1'b1, 20'h00001, 1'b0, 0);
    run("cmp0",    2'b11, 16'h1234, 1'b0, 20'h00000, 1'b0, 0);
    run("bp_max",  2'b10, 16'hFFFF, 1'b0, 20'h65535, 1'b0, 10);
    run("sub_min", 2'b01, 16'h8000, 1'b0, 20'h32768, 1'b1, 0);

    // Reset in the middle of a conversion discards it
    @(negedge clk);
    bus.fct_i = 2'b00; bus.s_i = 16'd4321; bus.valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_valid", 32'(bus.valid_o), 32'd0);
    chk("midrst_ready", 32'(bus.ready_o), 32'd1);
    chk("midrst_bcd",   32'(bus.bcd_o),   32'd0);
    chk("midrst_neg",   32'(bus.neg_o),   32'd0);
    run("after_rst", 2'b00, 16'd100, 1'b0, 20'h00100, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
